// File: rtl/arith_pkg.sv
// ============================================================================
// Module  : arith_pkg
// Purpose : Shared constants and state encodings for the lab arithmetic set.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package arith_pkg;

  localparam int ARITH_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_sub_divide_step.sv
// ============================================================================
// Module  : sub_cmp_step
// Purpose : One restoring-division step: trial subtract on WIDTH+1 bits,
//           restore on borrow, and produce the new quotient bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_cmp_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  // minuend < 2*divisor always holds, so the sign bit of the difference is the borrow
  assign w_diff   = minuend - {1'b0, divisor};
  assign w_borrow = w_diff[WIDTH];
  assign q_bit    = ~w_borrow;
  assign rem_next = w_borrow ? minuend[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/shift_sub_divide.sv
// ============================================================================
// Module  : shift_sub_divide
// Purpose : Sequential restoring divider, one quotient bit per clock, with a
//           start/busy/done handshake and divide-by-zero reporting.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_sub_divide
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;

  // The stored partial remainder is always below the divisor, so it fits in
  // WIDTH bits; the shifted trial value needs WIDTH+1.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};

  sub_cmp_step #(.WIDTH(WIDTH)) u_step (
    .minuend  (w_rem_sh),
    .divisor  (r_dvs),
    .rem_next (w_rem_next),
    .q_bit    (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dvs <= divisor;
            r_quo <= dividend;
            r_rem <= '0;
            r_cnt <= '0;
            if (divisor == '0) begin
              r_state     <= ST_FIN;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end else begin
              r_state     <= ST_RUN;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state   <= ST_FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {r_quo[WIDTH-2:0], w_q_bit};
            remainder <= w_rem_next;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_sub_divide.sv
// ============================================================================
// Module  : tb_shift_sub_divide
// Purpose : Directed, table-driven self-checking bench for shift_sub_divide.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_sub_divide;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  shift_sub_divide #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the divider in IDLE; pulses start for one edge.
  task automatic run_div(input vec_t v);
    int cyc = 0;
    int busy_n = 0;
    int lat_exp;
    logic [W-1:0] q_seen;
    dividend = v.dd;
    divisor  = v.dv;
    start    = 1'b1;
    lat_exp  = v.dz ? 1 : W + 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) break;
    end
    chk("latency", 64'(cyc), 64'(lat_exp));
    chk("busy_cycles", 64'(busy_n), v.dz ? 64'd0 : 64'(W));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("quotient", 64'(quotient), 64'(v.q));
    chk("remainder", 64'(remainder), 64'(v.r));
    chk("div_by_zero", 64'(div_by_zero), 64'(v.dz));
    q_seen = quotient;
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("quotient_held", 64'(quotient), 64'(q_seen));
  endtask

  initial begin
    int cyc;
    int ndone;
    int d1_cyc;
    int d2_cyc;
    logic [W-1:0] q1, r1, q2, r2;

    vecs[0] = '{32'd25, 32'd5, 32'd5, 32'd0, 1'b0};
    vecs[1] = '{32'd7, 32'd2, 32'd3, 32'd1, 1'b0};
    vecs[2] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
    vecs[5] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
    vecs[6] = '{32'd0, 32'd7, 32'd0, 32'd0, 1'b0};
    vecs[7] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[8] = '{32'd1000000, 32'd3, 32'd333333, 32'd1, 1'b0};
    vecs[9] = '{32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) run_div(vecs[k]);

    // start held high: 7/2, then 3/10 picked up in the IDLE cycle after FIN
    dividend = 32'd7; divisor = 32'd2; start = 1'b1;
    cyc = 0; ndone = 0; d1_cyc = 0; d2_cyc = 0;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int i = 0; i < 100 && ndone < 2; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin dividend = 32'd3; divisor = 32'd10; end
      if (cyc == 35) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1_cyc = cyc; q1 = quotient; r1 = remainder; end
        else begin d2_cyc = cyc; q2 = quotient; r2 = remainder; end
      end
    end
    chk("b2b_ndone", 64'(ndone), 64'd2);
    chk("b2b_lat1", 64'(d1_cyc), 64'd33);
    chk("b2b_q1", 64'(q1), 64'd3);
    chk("b2b_r1", 64'(r1), 64'd1);
    chk("b2b_lat2", 64'(d2_cyc), 64'd67);
    chk("b2b_q2", 64'(q2), 64'd0);
    chk("b2b_r2", 64'(r2), 64'd3);
    @(negedge clk);

    // operand change and a second start mid-run are both ignored
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    cyc = 0; ndone = 0; d1_cyc = 0; q1 = '0; r1 = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 5) begin dividend = 32'd50; divisor = 32'd3; end
      start = (cyc == 10);
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1_cyc = cyc; q1 = quotient; r1 = remainder; end
      end
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_lat", 64'(d1_cyc), 64'd33);
    chk("ign_q", 64'(q1), 64'd14);
    chk("ign_r", 64'(r1), 64'd2);

    // reset mid-division aborts it without a done pulse
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort_quiet", 64'(ndone), 64'd0);
    run_div('{32'd9, 32'd3, 32'd3, 32'd0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
